// File: rtl/delay_pulse_gen_pkg.sv
// delay_pulse_gen_pkg
//   Shared types and constants for the delayed pulse generator.
//   - state_t       : controller state encoding (IDLE, DELAY, PULSE, DONE)
//   - DEFAULT_WIDTH : default bit width of the delay/width/count fields
package delay_pulse_gen_pkg;

  localparam int DEFAULT_WIDTH = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_PULSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/delay_pulse_gen_down_counter.sv
// down_counter
//   Loadable down-counter that saturates at zero.
//   Ports:
//     clk        : rising-edge clock
//     rstb       : asynchronous active-low reset, clears value
//     load       : load load_value (has priority over dec)
//     load_value : value to load
//     dec        : decrement by one if value is non-zero
//     value      : current count
//     zero       : value == 0
module down_counter
  import delay_pulse_gen_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic [WIDTH-1:0] value,
  output logic             zero
);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (dec && (value != '0)) begin
      // Guarded so the count can never wrap below zero.
      value <= value - WIDTH'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/delay_pulse_gen.sv
// delay_pulse_gen
//   Generates a single pulse of `width` cycles, `delay` cycles after a start
//   request, followed by a one-cycle done strobe.
//   Ports:
//     clk       : rising-edge clock
//     rstb      : asynchronous active-low reset
//     start     : request an operation; sampled only in IDLE
//     abort     : synchronous cancel; wins over start in IDLE
//     delay     : cycles before the pulse, captured with start
//     width     : pulse length in cycles, captured with start
//     busy      : high whenever the controller is not IDLE
//     pulse     : timed pulse, high exactly while in PULSE
//     done      : one-cycle completion strobe (not raised on abort/reset)
//     remaining : current down-count value, 0 in IDLE
//
//   Handshake: start is a level request with no ready; it is accepted only
//   on an edge where the controller is IDLE and abort is low, otherwise it is
//   dropped (no queuing). done is a single-cycle strobe with no backpressure.
//
//   Timing with start sampled at edge 0: pulse is high after edges
//   delay+1 .. delay+width, done after edge delay+width+1, IDLE again after
//   edge delay+width+2. width=0 skips PULSE entirely.
module delay_pulse_gen
  import delay_pulse_gen_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] delay,
  input  logic [WIDTH-1:0] width,
  output logic             busy,
  output logic             pulse,
  output logic             done,
  output logic [WIDTH-1:0] remaining
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] w_q;
  logic             w_load;

  logic             cnt_load;
  logic [WIDTH-1:0] cnt_load_value;
  logic             cnt_dec;
  logic [WIDTH-1:0] cnt_value;
  logic             cnt_zero;

  down_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk        (clk),
    .rstb       (rstb),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .dec        (cnt_dec),
    .value      (cnt_value),
    .zero       (cnt_zero)
  );

  // State register and latched pulse width.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      if (w_load) begin
        w_q <= width;
      end
    end
  end

  // Next-state and counter control.
  always_comb begin
    state_d        = state_q;
    w_load         = 1'b0;
    cnt_load       = 1'b0;
    cnt_load_value = '0;
    cnt_dec        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d        = ST_DELAY;
          w_load         = 1'b1;
          cnt_load       = 1'b1;
          cnt_load_value = delay;
        end
      end

      ST_DELAY: begin
        if (abort) begin
          // Loading zero clears the count so remaining reads 0 in IDLE.
          state_d  = ST_IDLE;
          cnt_load = 1'b1;
        end else if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else if (w_q != '0) begin
          // Count W-1 down to 0 so PULSE lasts exactly W cycles.
          state_d        = ST_PULSE;
          cnt_load       = 1'b1;
          cnt_load_value = w_q - WIDTH'(1);
        end else begin
          state_d = ST_DONE;
        end
      end

      ST_PULSE: begin
        if (abort) begin
          state_d  = ST_IDLE;
          cnt_load = 1'b1;
        end else if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        // Count is already 0 here; start is ignored for this cycle.
        state_d = ST_IDLE;
      end

      default: begin
        state_d  = ST_IDLE;
        cnt_load = 1'b1;
      end
    endcase
  end

  // Outputs decode the state register only; no input reaches them
  // combinationally.
  always_comb begin
    busy  = (state_q != ST_IDLE);
    pulse = (state_q == ST_PULSE);
    done  = (state_q == ST_DONE);
  end

  assign remaining = cnt_value;

endmodule

// File: tb/tb_delay_pulse_gen.sv
// tb_delay_pulse_gen
//   Directed bench for delay_pulse_gen. The driver pushes the hand-computed
//   response of each accepted operation ({pulse rise offset, pulse length,
//   done offset}, offsets counted in edges from the accepting edge) into
//   exp_q; the monitor measures the DUT at every falling edge and pops and
//   compares whenever done is presented.
module tb_delay_pulse_gen;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rstb;
  logic         start;
  logic         abort;
  logic [W-1:0] delay;
  logic [W-1:0] width;
  logic         busy;
  logic         pulse;
  logic         done;
  logic [W-1:0] remaining;

  int checks = 0;
  int passes = 0;
  int edge_cnt = 0;

  logic [47:0] exp_q[$];

  delay_pulse_gen #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rstb      (rstb),
    .start     (start),
    .abort     (abort),
    .delay     (delay),
    .width     (width),
    .busy      (busy),
    .pulse     (pulse),
    .done      (done),
    .remaining (remaining)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #1_000_000;
    checks++;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // ---------------- helpers / driver tasks ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_exp(input int rise_off, input int plen, input int done_off);
    exp_q.push_back({rise_off[15:0], plen[15:0], done_off[15:0]});
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      tick();
      n++;
    end
    if (busy) begin
      checks++;
      $display("FAIL wait_idle_timeout: busy still %0d after %0d cycles, expected 0", busy, limit);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int          op_start = 0;
  int          rise_off = 0;
  int          plen = 0;
  logic        busy_prev = 1'b0;
  logic        pulse_prev = 1'b0;
  logic        idle_pending = 1'b0;
  logic [47:0] e;

  always @(negedge clk) begin
    if (idle_pending) begin
      check("busy_low_after_done", int'(busy), 0);
      idle_pending = 1'b0;
    end
    if (busy && !busy_prev) begin
      op_start = edge_cnt;
      rise_off = 0;
      plen     = 0;
    end
    if (pulse) begin
      if (!pulse_prev) rise_off = edge_cnt - op_start;
      plen++;
    end
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: done=1 at offset %0d, expected no done", edge_cnt - op_start);
      end else begin
        e = exp_q.pop_front();
        check("pulse_rise_offset", rise_off, int'(e[47:32]));
        check("pulse_length", plen, int'(e[31:16]));
        check("done_offset", edge_cnt - op_start, int'(e[15:0]));
      end
      idle_pending = 1'b1;
    end
    busy_prev  = busy;
    pulse_prev = pulse;
  end

  // ---------------- stimulus ----------------
  initial begin
    rstb  = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    delay = '0;
    width = '0;

    // Reset state.
    ticks(2);
    check("reset_busy", int'(busy), 0);
    check("reset_pulse", int'(pulse), 0);
    check("reset_done", int'(done), 0);
    check("reset_remaining", int'(remaining), 0);

    // delay=3 width=2, start accepted at the first edge after release.
    rstb  = 1'b1;
    start = 1'b1;
    delay = 12'd3;
    width = 12'd2;
    push_exp(4, 2, 6);
    tick();
    start = 1'b0;
    check("a_busy_after_start", int'(busy), 1);
    check("a_remaining_after_start", int'(remaining), 3);
    check("a_pulse_after_start", int'(pulse), 0);
    wait_idle(20);

    // delay=0 width=0: no pulse, done after edge 1, busy for 2 cycles.
    start = 1'b1;
    delay = 12'd0;
    width = 12'd0;
    push_exp(0, 0, 1);
    tick();
    start = 1'b0;
    wait_idle(10);

    // delay=5 width=4: abort sampled while in PULSE.
    start = 1'b1;
    delay = 12'd5;
    width = 12'd4;
    tick();
    start = 1'b0;
    ticks(6);
    check("c_pulse_before_abort", int'(pulse), 1);
    check("c_remaining_before_abort", int'(remaining), 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("c_pulse_after_abort", int'(pulse), 0);
    check("c_busy_after_abort", int'(busy), 0);
    check("c_done_after_abort", int'(done), 0);
    check("c_remaining_after_abort", int'(remaining), 0);
    ticks(8);

    // abort and start together in IDLE: abort wins.
    start = 1'b1;
    abort = 1'b1;
    delay = 12'd3;
    width = 12'd3;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("d_abort_wins_busy", int'(busy), 0);
    check("d_abort_wins_remaining", int'(remaining), 0);

    // delay=2 width=3 with start held high while busy; inputs changed after
    // capture. Start in the DONE cycle is ignored, the next one from IDLE is
    // accepted with the new inputs (delay=1 width=1).
    start = 1'b1;
    delay = 12'd2;
    width = 12'd3;
    push_exp(3, 3, 6);
    tick();
    delay = 12'd1;
    width = 12'd1;
    ticks(7);
    check("e_idle_after_done_with_start", int'(busy), 0);
    push_exp(2, 1, 3);
    tick();
    start = 1'b0;
    check("e_second_op_busy", int'(busy), 1);
    check("e_second_op_remaining", int'(remaining), 1);
    wait_idle(10);

    // Full-range delay=4095 width=4095.
    start = 1'b1;
    delay = 12'd4095;
    width = 12'd4095;
    push_exp(4096, 4095, 8191);
    tick();
    start = 1'b0;
    check("f_remaining_edge0", int'(remaining), 4095);
    ticks(4095);
    check("f_remaining_edge4095", int'(remaining), 0);
    check("f_pulse_edge4095", int'(pulse), 0);
    check("f_busy_edge4095", int'(busy), 1);
    tick();
    check("f_pulse_edge4096", int'(pulse), 1);
    check("f_remaining_edge4096", int'(remaining), 4094);
    ticks(4094);
    check("f_pulse_edge8190", int'(pulse), 1);
    check("f_remaining_edge8190", int'(remaining), 0);
    tick();
    check("f_done_edge8191", int'(done), 1);
    check("f_remaining_edge8191", int'(remaining), 0);
    tick();
    check("f_busy_edge8192", int'(busy), 0);

    // Reset pulsed mid-DELAY: outputs clear at once, no done.
    start = 1'b1;
    delay = 12'd10;
    width = 12'd2;
    tick();
    start = 1'b0;
    ticks(3);
    #2;
    rstb = 1'b0;
    #1;
    check("g_reset_busy", int'(busy), 0);
    check("g_reset_pulse", int'(pulse), 0);
    check("g_reset_done", int'(done), 0);
    check("g_reset_remaining", int'(remaining), 0);
    tick();
    rstb  = 1'b1;
    start = 1'b1;
    delay = 12'd1;
    width = 12'd1;
    push_exp(2, 1, 3);
    tick();
    start = 1'b0;
    check("g_start_after_release", int'(busy), 1);
    wait_idle(10);

    ticks(3);
    check("exp_queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
